// File: rtl/encoder_2ri12_pkg.sv
// Shared op codes, LoongArch32 2RI12 major opcodes and the instruction word layout.
// The id-stage 2RI12 decoder compares against the same OPC_* values.
package encoder_2ri12_pkg;

   // Decoded-op codes carried on in_op
   localparam logic [7:0] OP_INVALID = 8'h00;
   localparam logic [7:0] OP_SLTI    = 8'h01;
   localparam logic [7:0] OP_SLTUI   = 8'h02;
   localparam logic [7:0] OP_ADDI    = 8'h03;
   localparam logic [7:0] OP_ANDI    = 8'h04;
   localparam logic [7:0] OP_ORI     = 8'h05;
   localparam logic [7:0] OP_XORI    = 8'h06;
   localparam logic [7:0] OP_CACOP   = 8'h07;
   localparam logic [7:0] OP_LD      = 8'h08;
   localparam logic [7:0] OP_ST      = 8'h09;
   localparam logic [7:0] OP_LDU     = 8'h0A;

   localparam logic [9:0] OPC_SLTI   = 10'b0000001000;
   localparam logic [9:0] OPC_SLTUI  = 10'b0000001001;
   localparam logic [9:0] OPC_ADDI   = 10'b0000001010;
   localparam logic [9:0] OPC_ANDI   = 10'b0000001101;
   localparam logic [9:0] OPC_ORI    = 10'b0000001110;
   localparam logic [9:0] OPC_XORI   = 10'b0000001111;
   localparam logic [9:0] OPC_CACOP  = 10'b0000011000;

   // Memory ops carry the access size in the two low opcode bits
   localparam logic [7:0] OPC_LD_PFX  = 8'b00101000;
   localparam logic [7:0] OPC_ST_PFX  = 8'b00101001;
   localparam logic [7:0] OPC_LDU_PFX = 8'b00101010;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_RSV  = 2'd3
   } acc_sz_e;

   typedef struct packed {
      logic [9:0]  opc;
      logic [11:0] imm;
      logic [4:0]  rj;
      logic [4:0]  rd;
   } inst_2ri12_t;

   function automatic logic [31:0] pack_inst(input logic [9:0] opc, input logic [11:0] imm,
                                             input logic [4:0] rj, input logic [4:0] rd);
      inst_2ri12_t w;
      w.opc = opc;
      w.imm = imm;
      w.rj  = rj;
      w.rd  = rd;
      return w;
   endfunction

endpackage

// File: rtl/encoder_2ri12_fifo2.sv
// 2-entry 32-bit FIFO, registered output, one cycle push-to-pop latency.
// Push is refused at count 2 even if a pop happens that cycle (no pass-through).
module inst_fifo2 (
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_push_vld,
   output logic        o_push_rdy,
   input  logic [31:0] i_push_dat,
   output logic        o_pop_vld,
   input  logic        i_pop_rdy,
   output logic [31:0] o_pop_dat,
   output logic [1:0]  o_count
);

   logic [31:0] r_mem [2];
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [1:0]  r_cnt;
   logic        w_push;
   logic        w_pop;

   assign o_push_rdy = (r_cnt != 2'd2);
   assign o_pop_vld  = (r_cnt != 2'd0);
   assign o_pop_dat  = r_mem[r_rd_ptr];
   assign o_count    = r_cnt;

   assign w_push = i_push_vld && o_push_rdy;
   assign w_pop  = i_pop_rdy && o_pop_vld;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/encoder_2ri12.sv
// Encodes a decoded 2RI12 field bundle into a LoongArch32 word; legal words reach out_inst
// one cycle after accept via a 2-entry buffer, illegal bundles are dropped with a one-cycle err.
module encoder_2ri12
   import encoder_2ri12_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_op,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rj,
   input  logic [11:0]      in_imm,
   input  logic [1:0]       in_sz,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic             err,
   output logic [CNT_W-1:0] emit_cnt
);

   acc_sz_e          w_sz;
   logic [9:0]       w_opc;
   logic             w_legal;
   logic [31:0]      w_word;
   logic             w_acc;
   logic             w_push;
   logic             w_pop;
   logic             w_push_rdy;
   logic [1:0]       w_count;
   logic             r_err;
   logic [CNT_W-1:0] r_emit_cnt;

   assign w_sz = acc_sz_e'(in_sz);

   always_comb begin
      w_opc   = '0;
      w_legal = 1'b1;
      case (in_op)
         OP_SLTI:  w_opc = OPC_SLTI;
         OP_SLTUI: w_opc = OPC_SLTUI;
         OP_ADDI:  w_opc = OPC_ADDI;
         OP_ANDI:  w_opc = OPC_ANDI;
         OP_ORI:   w_opc = OPC_ORI;
         OP_XORI:  w_opc = OPC_XORI;
         OP_CACOP: w_opc = OPC_CACOP;
         OP_LD: begin
            w_opc   = {OPC_LD_PFX, w_sz};
            w_legal = (w_sz != SZ_RSV);
         end
         OP_ST: begin
            w_opc   = {OPC_ST_PFX, w_sz};
            w_legal = (w_sz != SZ_RSV);
         end
         // Unsigned loads exist only for byte and half
         OP_LDU: begin
            w_opc   = {OPC_LDU_PFX, w_sz};
            w_legal = (w_sz == SZ_BYTE) || (w_sz == SZ_HALF);
         end
         default: w_legal = 1'b0;
      endcase
   end

   assign w_word = pack_inst(w_opc, in_imm, in_rj, in_rd);

   // Gating with resetn keeps the bundle from being counted as accepted while reset is held
   assign in_ready = resetn && (w_count != 2'd2);
   assign w_acc    = in_valid && in_ready;
   assign w_push   = w_acc && w_legal && w_push_rdy;
   assign w_pop    = out_valid && out_ready;

   inst_fifo2 u_fifo (
      .clk        (clk),
      .resetn     (resetn),
      .i_push_vld (w_push),
      .o_push_rdy (w_push_rdy),
      .i_push_dat (w_word),
      .o_pop_vld  (out_valid),
      .i_pop_rdy  (out_ready),
      .o_pop_dat  (out_inst),
      .o_count    (w_count)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_err      <= 1'b0;
         r_emit_cnt <= '0;
      end else begin
         r_err <= w_acc && !w_legal;
         if (w_pop) begin
            r_emit_cnt <= r_emit_cnt + 1'b1;
         end
      end
   end

   assign err      = r_err;
   assign emit_cnt = r_emit_cnt;

endmodule

// File: tb/tb_encoder_2ri12.sv
// Directed and randomized checks of encoder_2ri12 against a queue-based reference model.
module tb_encoder_2ri12;
   import encoder_2ri12_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_op;
   logic [4:0]  in_rd;
   logic [4:0]  in_rj;
   logic [11:0] in_imm;
   logic [1:0]  in_sz;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        err;
   logic [15:0] emit_cnt;

   always #5 clk = ~clk;

   encoder_2ri12 #(.CNT_W(16)) dut (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rj(in_rj), .in_imm(in_imm), .in_sz(in_sz),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .err(err), .emit_cnt(emit_cnt)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] m_q[$];
   logic [15:0] m_emit = 16'd0;
   logic        m_err  = 1'b0;

   // Reference encoding from the architectural opcode table, plain arithmetic
   function automatic logic [31:0] ref_enc(input logic [7:0] op, input logic [4:0] rd,
                                           input logic [4:0] rj, input logic [11:0] imm,
                                           input logic [1:0] sz, output bit legal);
      int unsigned opc;
      legal = 1'b1;
      opc   = 0;
      case (op)
         OP_SLTI:  opc = 8;
         OP_SLTUI: opc = 9;
         OP_ADDI:  opc = 10;
         OP_ANDI:  opc = 13;
         OP_ORI:   opc = 14;
         OP_XORI:  opc = 15;
         OP_CACOP: opc = 24;
         OP_LD:  begin opc = 40 * 4 + sz; legal = (sz < 3); end
         OP_ST:  begin opc = 41 * 4 + sz; legal = (sz < 3); end
         OP_LDU: begin opc = 42 * 4 + sz; legal = (sz < 2); end
         default: legal = 1'b0;
      endcase
      return 32'(opc * 4194304 + imm * 1024 + rj * 32 + rd);
   endfunction

   task automatic cycle();
      bit          lg;
      logic [31:0] w;
      if (!resetn) begin
         m_q.delete();
         m_emit = 16'd0;
         m_err  = 1'b0;
      end else begin
         w     = ref_enc(in_op, in_rd, in_rj, in_imm, in_sz, lg);
         m_err = 1'b0;
         if (in_valid && m_q.size() < 2) begin
            m_err = !lg;
            if (out_ready && m_q.size() > 0) begin
               void'(m_q.pop_front());
               m_emit++;
            end
            if (lg) m_q.push_back(w);
         end else if (out_ready && m_q.size() > 0) begin
            void'(m_q.pop_front());
            m_emit++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'(resetn && m_q.size() < 2));
      chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) chk({tag, "_out_inst"}, out_inst, m_q[0]);
      chk({tag, "_err"}, 32'(err), 32'(m_err));
      chk({tag, "_emit_cnt"}, 32'(emit_cnt), 32'(m_emit));
   endtask

   task automatic drive(input logic v, input logic [7:0] op, input logic [4:0] rd,
                        input logic [4:0] rj, input logic [11:0] imm, input logic [1:0] sz);
      in_valid = v;
      in_op    = op;
      in_rd    = rd;
      in_rj    = rj;
      in_imm   = imm;
      in_sz    = sz;
   endtask

   initial begin
      resetn    = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, OP_INVALID, 5'd0, 5'd0, 12'd0, 2'd0);

      // Reset state
      cycle();
      cycle();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_inst", out_inst, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_emit", 32'(emit_cnt), 32'd0);
      resetn = 1'b1;
      cycle();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // addi with the largest positive immediate
      out_ready = 1'b1;
      drive(1'b1, OP_ADDI, 5'd1, 5'd2, 12'h7FF, 2'd0);
      cycle();
      chk("addi_inst", out_inst, 32'h029FFC41);
      check_all("addi");
      in_valid = 1'b0;
      cycle();
      chk("addi_emit", 32'(emit_cnt), 32'd1);
      check_all("addi_pop");

      // ld.w then ld.bu on the same fields
      out_ready = 1'b0;
      drive(1'b1, OP_LD, 5'd4, 5'd3, 12'h010, 2'd2);
      cycle();
      chk("ldw_inst", out_inst, 32'h28804064);
      check_all("ldw");
      out_ready = 1'b1;
      drive(1'b1, OP_LDU, 5'd4, 5'd3, 12'h010, 2'd0);
      cycle();
      chk("ldbu_inst", out_inst, 32'h2A004064);
      check_all("ldbu");
      in_valid = 1'b0;
      cycle();
      check_all("ldbu_pop");

      // Three back-to-back illegal bundles
      drive(1'b1, OP_LDU, 5'd1, 5'd1, 12'h001, 2'd2);
      cycle();
      chk("ill0_err", 32'(err), 32'd1);
      check_all("ill0");
      drive(1'b1, OP_ST, 5'd1, 5'd1, 12'h001, 2'd3);
      cycle();
      chk("ill1_err", 32'(err), 32'd1);
      check_all("ill1");
      drive(1'b1, OP_INVALID, 5'd1, 5'd1, 12'h001, 2'd0);
      cycle();
      chk("ill2_err", 32'(err), 32'd1);
      chk("ill2_out_valid", 32'(out_valid), 32'd0);
      check_all("ill2");
      in_valid = 1'b0;
      cycle();
      chk("ill_end_err", 32'(err), 32'd0);
      check_all("ill_end");

      // Backpressure: third bundle waits for the first pop
      out_ready = 1'b0;
      drive(1'b1, OP_ORI, 5'd5, 5'd6, 12'h123, 2'd0);
      cycle();
      chk("bp1_in_ready", 32'(in_ready), 32'd1);
      drive(1'b1, OP_XORI, 5'd7, 5'd8, 12'hABC, 2'd0);
      cycle();
      chk("bp2_in_ready", 32'(in_ready), 32'd0);
      drive(1'b1, OP_CACOP, 5'd9, 5'd10, 12'hFFF, 2'd3);
      cycle();
      check_all("bp_hold");
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) in_valid = 1'b0;
         cycle();
         check_all("bp_drain");
      end

      // Count 1 with simultaneous push and pop
      out_ready = 1'b0;
      drive(1'b1, OP_SLTI, 5'd11, 5'd12, 12'h800, 2'd0);
      cycle();
      out_ready = 1'b1;
      drive(1'b1, OP_SLTUI, 5'd13, 5'd14, 12'h00F, 2'd1);
      cycle();
      chk("pp_in_ready", 32'(in_ready), 32'd1);
      check_all("pp");
      in_valid = 1'b0;
      cycle();
      check_all("pp_drain");

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 12)), 5'($urandom),
               5'($urandom), 12'($urandom), 2'($urandom));
         out_ready = 1'($urandom_range(0, 2) != 0);
         cycle();
         check_all("rand");
      end

      // Reset with two words buffered
      out_ready = 1'b0;
      drive(1'b1, OP_ANDI, 5'd2, 5'd3, 12'h456, 2'd0);
      cycle();
      cycle();
      cycle();
      chk("prerst_out_valid", 32'(out_valid), 32'd1);
      drive(1'b1, OP_LD, 5'd1, 5'd1, 12'h001, 2'd3);
      resetn = 1'b0;
      cycle();
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_emit", 32'(emit_cnt), 32'd0);
      chk("midrst_err", 32'(err), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      resetn   = 1'b1;
      in_valid = 1'b0;
      cycle();
      check_all("after_rst");

      // emit_cnt wrap: bounded run of single-word pops
      out_ready = 1'b1;
      drive(1'b1, OP_ADDI, 5'd1, 5'd1, 12'h001, 2'd0);
      for (int i = 0; i < 70000 && m_emit != 16'hFFFF; i++) cycle();
      chk("wrap_pre", 32'(emit_cnt), 32'h0000FFFF);
      cycle();
      chk("wrap_post", 32'(emit_cnt), 32'd0);
      check_all("wrap");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/encoder_2ri12.md
# encoder_2ri12

Instruction encoder for LoongArch32 2RI12-format instructions: it turns a decoded field bundle (`OP_*` code, rd, rj, si12/ui12, access size) back into a 32-bit instruction word. It is the inverse of the id-stage 2RI12 decoder and sits in the debug/instruction-injection path, feeding encoded words to the IF-stage inject port through a 2-entry output buffer. Illegal field combinations are dropped and flagged, never emitted.

## Interface
Parameters:
- `CNT_W`, 16, width of the emitted-instruction counter.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  the block accepts the bundle this cycle.
- `in_op`  in  8  `OP_*` code from defs.v.
- `in_rd`  in  5  rd field; for `OP_CACOP` this is the cache op code.
- `in_rj`  in  5  rj field.
- `in_imm`  in  12  immediate, placed raw into inst[21:10].
- `in_sz`  in  2  access size for LD/ST/LDU: 0=byte, 1=half, 2=word.
- `out_valid`  out  1  an encoded word is available.
- `out_ready`  in  1  the consumer takes the word this cycle.
- `out_inst`  out  32  encoded instruction.
- `err`  out  1  one-cycle pulse: an accepted bundle was illegal and dropped.
- `emit_cnt`  out  CNT_W  count of words popped at the output; wraps.

## Operation
- Accept when `in_valid && in_ready`. Pop when `out_valid && out_ready`.
- Encoding: inst[31:22] = opcode, inst[21:10] = `in_imm`, inst[9:5] = `in_rj`, inst[4:0] = `in_rd`.
- Opcode for each op:
  - SLTI = 0000001000.
  - SLTUI = 0000001001.
  - ADDI = 0000001010.
  - ANDI = 0000001101.
  - ORI = 0000001110.
  - XORI = 0000001111.
  - CACOP = 0000011000.
  - LD = 00101000 followed by `in_sz`.
  - ST = 00101001 followed by `in_sz`.
  - LDU = 00101010 followed by `in_sz`.
- Legality:
  - Any `in_op` not in the list above is illegal, including `OP_INVALID`.
  - LD/ST with `in_sz` = 3 are illegal.
  - LDU with `in_sz` ≥ 2 are illegal.
  - `in_sz` is ignored for all other ops.
- Legal accepted bundles are pushed into the 2-entry FIFO.
- Illegal accepted bundles are not pushed. `err` pulses in the cycle after acceptance.
- `in_ready` = FIFO count < 2. A pop in the same cycle does not open a full FIFO (no pass-through).
- Simultaneous push and pop at count 1 leaves the count at 1 and preserves order.
- `emit_cnt` increments on every pop and wraps from 2^CNT_W−1 to 0.

## Timing
- Latency: a legal word accepted in cycle N appears on `out_inst` with `out_valid` high in cycle N+1. There is no combinational path from input to output.
- `out_inst` holds stable while `out_valid && !out_ready`.
- Reset values (while `resetn` is low at a clock edge): FIFO count 0, `out_valid` 0, `out_inst` 0, `in_ready` 0 during reset then 1, `err` 0, `emit_cnt` 0.
- Reset mid-operation discards buffered words. No `err` pulse is generated for discarded words.
- `err` is registered and high for exactly one cycle per illegal bundle. Back-to-back illegal bundles give back-to-back pulses.

## Structure
- Add 10-bit constants `OPC_SLTI` … `OPC_CACOP` and 8-bit prefixes `OPC_LD_PFX`, `OPC_ST_PFX`, `OPC_LDU_PFX` to defs.v. The id-stage decoder then compares against the same values.
- Encoding and legality checking are a single combinational case on `in_op`.
- One sub-module, `inst_fifo2`: a 2-entry, 32-bit FIFO with valid/ready on both sides and a count output.

## Test plan
- ADDI, rd=1, rj=2, imm=0x7FF, out_ready=1 → out_inst=0x029FFC41 one cycle after accept; `emit_cnt`=1.
- LD, sz=2 (ld.w), rd=4, rj=3, imm=0x010 → out_inst=0x28804064. LDU, sz=0, same fields → 0x2A004064.
- LDU sz=2; then ST sz=3; then `in_op`=`OP_INVALID` → three consecutive `err` pulses, `out_valid` stays 0, `emit_cnt` unchanged.
- out_ready=0, push three legal bundles → `in_ready` drops after the second. out_ready=1 → words emerge in order, third accepted after first pop.
- Count 1 with push and pop in the same cycle → count stays 1 and order is preserved. Drive `resetn`=0 with 2 words buffered → next cycle `out_valid`=0, `emit_cnt`=0, no `err`.
- Preload `emit_cnt` to 0xFFFF via a run of 65535 pops, pop once more → `emit_cnt`=0.
